// File: rtl/ceespu_dmem_pkg.sv
// Shared constants, state and region encodings for the CEESPU data-memory responder.
package ceespu_dmem_pkg;

  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned IO_AW        = 12;
  localparam int unsigned LANES        = 4;
  localparam logic [15:0] RAM_BASE     = 16'h0000;
  localparam logic [15:0] IO_BASE_DEF  = 16'hF000;
  localparam logic [7:0]  TIMEOUT_DEF  = 8'd255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE    = 1'b0,
    IO_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    RAM      = 2'd0,
    IO       = 2'd1,
    UNMAPPED = 2'd2
  } region_t;

  // I/O wins if the regions ever overlap; RAM spans ram_bytes bytes from RAM_BASE.
  function automatic region_t decode_region(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W:0]   ram_bytes,
                                            input logic [ADDR_W-1:0] io_base);
    region_t r;
    if (addr >= io_base) begin
      r = IO;
    end else if (({1'b0, addr} - {1'b0, RAM_BASE}) < ram_bytes) begin
      r = RAM;
    end else begin
      r = UNMAPPED;
    end
    return r;
  endfunction

endpackage

// File: rtl/ceespu_dmem_ram.sv
// Single-port synchronous RAM with byte write enables and a registered read port.
module ceespu_dmem_ram
  import ceespu_dmem_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic              clk,
  input  logic              re,
  input  logic [LANES-1:0]  we,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [0:(1 << AW)-1];

  // Byte-lane writes and a read register that only moves on a read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/ceespu_dmem_responder.sv
// Data-memory target: decodes core requests into RAM, slow I/O (req/ack with timeout)
// or unmapped space, and returns read data, busy and a bus-error pulse.
module ceespu_dmem_responder
  import ceespu_dmem_pkg::*;
#(
  parameter int unsigned RAM_AW   = 12,
  parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
  parameter logic [7:0]  TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_memE,
  input  logic [3:0]        I_memWe,
  input  logic [ADDR_W-1:0] I_memAddress,
  input  logic [31:0]       I_memWData,
  output logic [31:0]       O_memRData,
  output logic              O_memBusy,
  output logic              O_busErr,
  output logic              O_ioReq,
  output logic [3:0]        O_ioWe,
  output logic [IO_AW-1:0]  O_ioAddress,
  output logic [31:0]       O_ioWData,
  input  logic [31:0]       I_ioRData,
  input  logic              I_ioAck
);

  localparam logic [ADDR_W:0] RAM_BYTES = 17'(32'd4 << RAM_AW);

  state_t      state_r;
  region_t     region_s;
  logic [7:0]  cnt_r;
  logic [31:0] hold_r;
  logic [31:0] ram_q_s;
  logic [3:0]  ram_we_s;
  logic        ram_sel_r;
  logic        io_read_r;
  logic        accept_s;
  logic        is_read_s;
  logic        ram_rd_s;

  assign accept_s  = I_memE && (state_r == IDLE);
  assign is_read_s = (I_memWe == 4'b0000);
  assign region_s  = decode_region(I_memAddress, RAM_BYTES, IO_BASE);
  assign ram_rd_s  = accept_s && (region_s == RAM) && is_read_s;
  assign ram_we_s  = (accept_s && (region_s == RAM)) ? I_memWe : 4'b0000;

  ceespu_dmem_ram #(.AW(RAM_AW)) u_ram (
    .clk   (I_clk),
    .re    (ram_rd_s),
    .we    (ram_we_s),
    .addr  (I_memAddress[RAM_AW+1:2]),
    .wdata (I_memWData),
    .rdata (ram_q_s)
  );

  // Both sources are registers; ram_sel_r records which one completed the last read.
  assign O_memRData = ram_sel_r ? ram_q_s : hold_r;

  // Request FSM, timeout counter and all registered outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r     <= IDLE;
      O_memBusy   <= 1'b0;
      O_busErr    <= 1'b0;
      O_ioReq     <= 1'b0;
      O_ioWe      <= 4'b0000;
      O_ioAddress <= {IO_AW{1'b0}};
      O_ioWData   <= 32'h0000_0000;
      cnt_r       <= 8'd0;
      hold_r      <= 32'h0000_0000;
      ram_sel_r   <= 1'b0;
      io_read_r   <= 1'b0;
    end else begin
      O_busErr <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (region_s)
              RAM: begin
                if (is_read_s) begin
                  ram_sel_r <= 1'b1;
                end else begin
                  ram_sel_r <= ram_sel_r;
                end
              end
              IO: begin
                O_ioReq     <= 1'b1;
                O_memBusy   <= 1'b1;
                O_ioWe      <= I_memWe;
                O_ioAddress <= I_memAddress[IO_AW-1:0];
                O_ioWData   <= I_memWData;
                io_read_r   <= is_read_s;
                cnt_r       <= TIMEOUT;
                state_r     <= IO_WAIT;
              end
              UNMAPPED: begin
                O_busErr <= 1'b1;
                if (is_read_s) begin
                  hold_r    <= 32'h0000_0000;
                  ram_sel_r <= 1'b0;
                end else begin
                  hold_r    <= hold_r;
                end
              end
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        IO_WAIT: begin
          // Ack is tested first so it beats a simultaneous expiry.
          if (I_ioAck) begin
            O_ioReq   <= 1'b0;
            O_memBusy <= 1'b0;
            cnt_r     <= 8'd0;
            state_r   <= IDLE;
            if (io_read_r) begin
              hold_r    <= I_ioRData;
              ram_sel_r <= 1'b0;
            end else begin
              hold_r    <= hold_r;
            end
          end else if (cnt_r <= 8'd1) begin
            O_ioReq   <= 1'b0;
            O_memBusy <= 1'b0;
            O_busErr  <= 1'b1;
            cnt_r     <= 8'd0;
            state_r   <= IDLE;
            if (io_read_r) begin
              hold_r    <= ERR_DATA;
              ram_sel_r <= 1'b0;
            end else begin
              hold_r    <= hold_r;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_dmem_responder.sv
// Randomized scoreboard bench for ceespu_dmem_responder against a word-array/queue reference model.
module tb_ceespu_dmem_responder;

  localparam logic [7:0]  TMO  = 8'd4;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_memE;
  logic [3:0]  I_memWe;
  logic [15:0] I_memAddress;
  logic [31:0] I_memWData;
  logic [31:0] O_memRData;
  logic        O_memBusy;
  logic        O_busErr;
  logic        O_ioReq;
  logic [3:0]  O_ioWe;
  logic [11:0] O_ioAddress;
  logic [31:0] O_ioWData;
  logic [31:0] I_ioRData;
  logic        I_ioAck;

  ceespu_dmem_responder #(
    .RAM_AW(12), .IO_BASE(16'hF000), .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_memE(I_memE), .I_memWe(I_memWe),
    .I_memAddress(I_memAddress), .I_memWData(I_memWData), .O_memRData(O_memRData),
    .O_memBusy(O_memBusy), .O_busErr(O_busErr), .O_ioReq(O_ioReq), .O_ioWe(O_ioWe),
    .O_ioAddress(O_ioAddress), .O_ioWData(O_ioWData), .I_ioRData(I_ioRData),
    .I_ioAck(I_ioAck)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // One expected response: busy/I-O latches hold over [wait_start, resp_cyc), response at resp_cyc.
  typedef struct {
    int          wait_start;
    int          resp_cyc;
    bit          rst;
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } item_t;

  item_t       q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_model [0:4095];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the front of the queue.
  initial begin : monitor
    item_t       it;
    logic [31:0] exp_last;
    bit          armed;
    armed = 1'b0;
    exp_last = 32'h0;
    forever begin
      @(negedge I_clk);
      if (q.size() > 0 && q[0].resp_cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_response: got none want response at cycle %0d", q[0].resp_cyc);
        it = q.pop_front();
      end
      if (q.size() > 0 && q[0].wait_start <= cyc && cyc < q[0].resp_cyc) begin
        check("wait_busy", 64'(O_memBusy), 64'd1);
        check("wait_ioreq", 64'(O_ioReq), 64'd1);
        check("wait_err", 64'(O_busErr), 64'd0);
        check("wait_io_latch", {16'h0, O_ioWe, O_ioAddress, O_ioWData},
              {16'h0, q[0].we, q[0].addr, q[0].wdata});
      end else if (q.size() > 0 && q[0].resp_cyc == cyc) begin
        it = q.pop_front();
        if (it.rst) exp_last = 32'h0;
        else if (it.rd) exp_last = it.rdata;
        armed = 1'b1;
        check("resp_busy", 64'(O_memBusy), 64'd0);
        check("resp_ioreq", 64'(O_ioReq), 64'd0);
        check("resp_buserr", 64'(O_busErr), 64'(it.err));
        check("resp_rdata", 64'(O_memRData), 64'(exp_last));
        if (it.rst) check("rst_io_latch", {16'h0, O_ioWe, O_ioAddress, O_ioWData}, 64'd0);
      end else if (armed) begin
        check("idle_busy", 64'(O_memBusy), 64'd0);
        check("idle_buserr", 64'(O_busErr), 64'd0);
        check("idle_ioreq", 64'(O_ioReq), 64'd0);
        check("idle_rdata_hold", 64'(O_memRData), 64'(exp_last));
      end
    end
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle(input int n);
    I_memE = 1'b0;
    I_memWe = 4'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Word addresses that were written during setup, low byte bits random.
  function automatic logic [15:0] pool_addr();
    int idx;
    logic [11:0] w;
    idx = $urandom_range(0, 15);
    w = (idx < 14) ? 12'(idx) : ((idx == 14) ? 12'd4094 : 12'd4095);
    return {2'b00, w, 2'($urandom)};
  endfunction

  // Issue one access; ack_dly is the I/O cycle in which ack arrives (beyond TMO: never).
  task automatic mem_op(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d,
                        input int ack_dly, input logic [31:0] iod, input bit stray);
    item_t it;
    int    w;
    bit    acked;
    it.wait_start = cyc + 1;
    it.rst = 1'b0;
    it.rd = (we == 4'h0);
    it.we = we;
    it.addr = a[11:0];
    it.wdata = d;
    it.err = 1'b0;
    it.rdata = 32'h0;
    I_memE = 1'b1;
    I_memWe = we;
    I_memAddress = a;
    I_memWData = d;
    if (a >= 16'hF000) begin
      acked = (ack_dly <= int'(TMO));
      w = acked ? ack_dly : int'(TMO);
      it.rdata = acked ? iod : ERRD;
      it.err = !acked;
      it.resp_cyc = cyc + 1 + w;
      q.push_back(it);
      tick();
      for (int j = 1; j <= w; j++) begin
        I_memE = 1'b1;
        I_memWe = 4'($urandom);
        I_memAddress = pool_addr();
        I_memWData = $urandom;
        I_ioAck = acked && (j == ack_dly);
        I_ioRData = (acked && (j == ack_dly)) ? iod : $urandom;
        tick();
      end
      I_memE = 1'b0;
      I_ioAck = stray;
      I_ioRData = $urandom;
      tick();
      I_ioAck = 1'b0;
    end else if (a < 16'h4000) begin
      it.resp_cyc = cyc + 1;
      if (it.rd) it.rdata = mem_model[a[13:2]];
      else mem_model[a[13:2]] = merge(mem_model[a[13:2]], d, we);
      q.push_back(it);
      tick();
    end else begin
      it.resp_cyc = cyc + 1;
      it.err = 1'b1;
      it.rdata = 32'h0;
      q.push_back(it);
      tick();
    end
  endtask

  task automatic reset_mid_io(input logic [15:0] a, input logic [31:0] d);
    item_t it;
    it.wait_start = cyc + 1;
    it.resp_cyc = cyc + 3;
    it.rst = 1'b1;
    it.rd = 1'b0;
    it.rdata = 32'h0;
    it.err = 1'b0;
    it.we = 4'hF;
    it.addr = a[11:0];
    it.wdata = d;
    q.push_back(it);
    I_memE = 1'b1;
    I_memWe = 4'hF;
    I_memAddress = a;
    I_memWData = d;
    tick();
    I_memE = 1'b0;
    tick();
    I_rst = 1'b1;
    tick();
    I_rst = 1'b0;
  endtask

  initial begin : stimulus
    item_t it;
    logic [15:0] a;
    logic [3:0]  we;
    int          r;
    I_rst = 1'b1;
    I_memE = 1'b0;
    I_memWe = 4'h0;
    I_memAddress = 16'h0;
    I_memWData = 32'h0;
    I_ioRData = 32'h0;
    I_ioAck = 1'b0;
    it.wait_start = cyc + 1;
    it.resp_cyc = cyc + 1;
    it.rst = 1'b1;
    it.rd = 1'b0;
    it.rdata = 32'h0;
    it.err = 1'b0;
    it.we = 4'h0;
    it.addr = 12'h0;
    it.wdata = 32'h0;
    q.push_back(it);
    tick();
    tick();
    I_rst = 1'b0;
    idle(1);

    for (int i = 0; i < 14; i++) mem_op({2'b00, 12'(i), 2'b00}, 4'hF, $urandom, 0, 32'h0, 1'b0);
    mem_op(16'h3FF8, 4'hF, $urandom, 0, 32'h0, 1'b0);
    mem_op(16'h3FFC, 4'hF, $urandom, 0, 32'h0, 1'b0);
    idle(1);

    // Byte lanes, then a back-to-back read of the same word.
    mem_op(16'h0010, 4'hF, 32'h1122_3344, 0, 32'h0, 1'b0);
    mem_op(16'h0010, 4'b0010, 32'h0000_AA00, 0, 32'h0, 1'b0);
    mem_op(16'h0010, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    idle(2);
    // I/O read acked in its third wait cycle, then a timeout, then an ack on expiry.
    mem_op(16'hF004, 4'h0, 32'h0, 3, 32'hCAFE_F00D, 1'b0);
    mem_op(16'hF100, 4'h0, 32'h0, 99, 32'h0, 1'b1);
    mem_op(16'hF00C, 4'h0, 32'h0, int'(TMO), 32'h1234_5678, 1'b0);
    mem_op(16'hFFFF, 4'h5, 32'hA5A5_5A5A, 99, 32'h0, 1'b0);
    // Unmapped edges, and RAM word 0 survives.
    mem_op(16'h8000, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    mem_op(16'h8000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    mem_op(16'h0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    mem_op(16'h4000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    mem_op(16'h3FFF, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    mem_op(16'hEFFF, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    mem_op(16'hF000, 4'h0, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    idle(1);
    reset_mid_io(16'hF008, 32'h5555_AAAA);
    idle(1);
    mem_op(16'h0010, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    idle(1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (r < 6) begin
        mem_op(pool_addr(), we, $urandom, 0, 32'h0, 1'b0);
      end else if (r < 8) begin
        a = 16'hF000 | 16'($urandom_range(0, 4095));
        mem_op(a, we, $urandom, $urandom_range(1, int'(TMO) + 2), $urandom,
               1'($urandom_range(0, 1)));
      end else begin
        a = 16'($urandom_range(16'h4000, 16'hEFFF));
        mem_op(a, we, $urandom, 0, 32'h0, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
